// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, N_DATA data bits LSB first, optional parity, M_STOP stop bits.
// Latency: start bit drives o_tx on the edge after acceptance; the frame lasts (1+N_DATA+PARITY_CHECK+M_STOP)*N_TICKS ticks.
// Backpressure: i_tx_start is honoured only in IDLE; requests while o_busy is high are dropped, not queued.
//
// Ports:
//   i_clk, i_rst    : clock (rising edge) and asynchronous active-high reset
//   i_tick          : baud x N_TICKS strobe, one i_clk cycle wide
//   i_tx_start      : transmit request, sampled only in IDLE
//   i_data          : byte to send, captured on the accepting cycle
//   o_tx            : registered serial line, idles high
//   o_busy          : high in every state except IDLE
//   o_tx_done       : one-cycle pulse in the first IDLE cycle after a frame
module uart_tx #(
  parameter int N_DATA          = 8,
  parameter int LOG2_N_DATA     = 4,
  parameter int PARITY_CHECK    = 0,
  parameter int EVEN_ODD_PARITY = 1,
  parameter int M_STOP          = 1,
  parameter int LOG2_M_STOP     = 1,
  parameter int N_TICKS         = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tick,
  input  logic              i_tx_start,
  input  logic [N_DATA-1:0] i_data,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_tx_done
);

  localparam int TICK_W = (N_TICKS > 1) ? $clog2(N_TICKS) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                  state_q, state_nxt;
  logic [TICK_W-1:0]       tick_cnt_q, tick_cnt_nxt;
  logic [LOG2_N_DATA-1:0]  bit_cnt_q, bit_cnt_nxt;
  logic [LOG2_M_STOP-1:0]  stop_cnt_q, stop_cnt_nxt;
  logic [N_DATA-1:0]       shreg_q, shreg_nxt;
  logic                    par_q, par_nxt;
  logic                    tx_q, tx_nxt;
  logic                    done_q, done_nxt;
  logic                    bit_end;
  logic                    last_data;
  logic                    last_stop;

  // A bit period closes on the tick that would take the counter past N_TICKS-1.
  assign bit_end   = i_tick && (tick_cnt_q == TICK_W'(N_TICKS - 1));
  assign last_data = (bit_cnt_q == LOG2_N_DATA'(N_DATA - 1));
  assign last_stop = (stop_cnt_q == LOG2_M_STOP'(M_STOP - 1));

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (i_tx_start) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && last_data) state_nxt = (PARITY_CHECK != 0) ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end && last_stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath next values: tick/bit/stop counters, shift register, parity
  always_comb begin
    tick_cnt_nxt = tick_cnt_q;
    bit_cnt_nxt  = bit_cnt_q;
    stop_cnt_nxt = stop_cnt_q;
    shreg_nxt    = shreg_q;
    par_nxt      = par_q;

    // Counter is held at zero in IDLE so a tick on the accepting cycle is not counted.
    if (state_q == IDLE)  tick_cnt_nxt = '0;
    else if (bit_end)     tick_cnt_nxt = '0;
    else if (i_tick)      tick_cnt_nxt = tick_cnt_q + TICK_W'(1);

    if (state_q == IDLE && i_tx_start) begin
      shreg_nxt = i_data;
      par_nxt   = (^i_data) ^ (EVEN_ODD_PARITY != 0);
    end

    if (state_q == START && bit_end) bit_cnt_nxt = '0;

    if (state_q == DATA && bit_end) begin
      shreg_nxt   = shreg_q >> 1;
      bit_cnt_nxt = bit_cnt_q + LOG2_N_DATA'(1);
    end

    if (state_q != STOP && state_nxt == STOP) stop_cnt_nxt = '0;
    else if (state_q == STOP && bit_end)      stop_cnt_nxt = stop_cnt_q + LOG2_M_STOP'(1);
  end

  // Output logic: line level is decoded from the state being entered, so the
  // registered o_tx lines up with state_q without a cycle of skew.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      IDLE:    tx_nxt = 1'b1;
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      PARITY:  tx_nxt = par_q;
      STOP:    tx_nxt = 1'b1;
      default: tx_nxt = 1'b1;
    endcase
    done_nxt = (state_q == STOP) && (state_nxt == IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_nxt;
      bit_cnt_q  <= bit_cnt_nxt;
      stop_cnt_q <= stop_cnt_nxt;
      shreg_q    <= shreg_nxt;
      par_q      <= par_nxt;
      tx_q       <= tx_nxt;
      done_q     <= done_nxt;
    end
  end

  assign o_tx      = tx_q;
  assign o_busy    = (state_q != IDLE);
  assign o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (8N1, 8E2, 8O1) share one stimulus stream
// and are compared every cycle against a frame-level model (list of line levels
// indexed by ticks elapsed since acceptance).
module tb_uart_tx;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_tick;
  logic       i_tx_start;
  logic [7:0] i_data;
  logic [2:0] tx_w, busy_w, done_w;

  localparam int PC [3] = '{0, 1, 1};
  localparam int EO [3] = '{1, 0, 1};
  localparam int MS [3] = '{1, 2, 1};

  int errors = 0;
  int checks = 0;

  bit          m_busy [3];
  bit          m_done [3];
  int          m_n    [3];
  int          m_nb   [3];
  logic [15:0] m_bits [3];
  int          busy_cnt [3];
  int          done_cnt [3];
  int          tick_mode;
  int          tick_ph;

  uart_tx dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick), .i_tx_start(i_tx_start),
    .i_data(i_data), .o_tx(tx_w[0]), .o_busy(busy_w[0]), .o_tx_done(done_w[0])
  );

  uart_tx #(.PARITY_CHECK(1), .EVEN_ODD_PARITY(0), .M_STOP(2), .LOG2_M_STOP(2)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick), .i_tx_start(i_tx_start),
    .i_data(i_data), .o_tx(tx_w[1]), .o_busy(busy_w[1]), .o_tx_done(done_w[1])
  );

  uart_tx #(.PARITY_CHECK(1), .EVEN_ODD_PARITY(1)) dut2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick), .i_tx_start(i_tx_start),
    .i_data(i_data), .o_tx(tx_w[2]), .o_busy(busy_w[2]), .o_tx_done(done_w[2])
  );

  initial forever #5 i_clk = ~i_clk;

  // Line level for each bit slot of a frame; slots past the frame read as idle-high.
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input int pc, input int eo);
    logic [15:0] v;
    v    = '1;
    v[0] = 1'b0;
    for (int k = 0; k < 8; k++) v[1+k] = d[k];
    if (pc != 0) v[9] = (eo != 0) ? ~(^d) : (^d);
    return v;
  endfunction

  task automatic chk(input logic obs, input logic exp, input string tag, input int idx);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] t=%0t observed=%b expected=%b", tag, idx, $time, obs, exp);
    end
  endtask

  task automatic chk_int(input int obs, input int exp, input string tag, input int idx);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] t=%0t observed=%0d expected=%0d", tag, idx, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 1'b0;
      m_done[i] = 1'b0;
      m_n[i]    = 0;
    end
  endtask

  // Advance the frame model by one clock edge using the inputs it sampled.
  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      m_done[i] = 1'b0;
      if (i_rst) begin
        m_busy[i] = 1'b0;
        m_n[i]    = 0;
      end else if (!m_busy[i]) begin
        if (i_tx_start) begin
          m_busy[i] = 1'b1;
          m_n[i]    = 0;
          m_bits[i] = frame_bits(i_data, PC[i], EO[i]);
        end
      end else if (i_tick) begin
        m_n[i]++;
        if (m_n[i] == m_nb[i] * 16) begin
          m_busy[i] = 1'b0;
          m_done[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk(tx_w[i], m_busy[i] ? m_bits[i][m_n[i] / 16] : 1'b1, "tx", i);
      chk(busy_w[i], m_busy[i], "busy", i);
      chk(done_w[i], m_done[i], "done", i);
      busy_cnt[i] += int'(busy_w[i]);
      done_cnt[i] += int'(done_w[i]);
    end
  endtask

  task automatic step();
    case (tick_mode)
      0:       i_tick = 1'b1;
      1: begin
        i_tick  = (tick_ph == 0);
        tick_ph = (tick_ph + 1) % 10;
      end
      default: i_tick = 1'($urandom_range(0, 1));
    endcase
    @(posedge i_clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] d);
    i_data     = d;
    i_tx_start = 1'b1;
    step();
    i_tx_start = 1'b0;
    i_data     = 8'($urandom);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin
      busy_cnt[i] = 0;
      done_cnt[i] = 0;
    end
  endtask

  initial begin
    int w;
    for (int i = 0; i < 3; i++) m_nb[i] = 1 + 8 + PC[i] + MS[i];
    model_reset();
    tick_mode  = 0;
    tick_ph    = 0;
    i_rst      = 1'b1;
    i_tick     = 1'b0;
    i_tx_start = 1'b0;
    i_data     = 8'h00;
    #1;
    check_all();
    run(3);
    i_rst = 1'b0;
    run(2);

    // 8N1 / 8E2 / 8O1 frame of 0x03 with a tick every clock
    clear_counts();
    send(8'h03);
    run(220);
    for (int i = 0; i < 3; i++) begin
      chk_int(busy_cnt[i], m_nb[i] * 16, "busy_cycles", i);
      chk_int(done_cnt[i], 1, "done_pulses", i);
    end

    // Parity: 0x0C has two ones -> even parity 0, odd parity 1
    clear_counts();
    send(8'h0C);
    run(220);
    for (int i = 0; i < 3; i++) chk_int(busy_cnt[i], m_nb[i] * 16, "busy_cycles_par", i);

    // Realistic baud: one tick every 10 clocks, 0x20
    tick_mode = 1;
    tick_ph   = 3;
    clear_counts();
    send(8'h20);
    run(12 * 16 * 10 + 40);
    for (int i = 0; i < 3; i++) chk_int(done_cnt[i], 1, "done_pulses_slow", i);

    // Start while busy is ignored, then back-to-back in dut0's done cycle
    tick_mode = 0;
    send(8'h03);
    run(40);
    i_data     = 8'hFF;
    i_tx_start = 1'b1;
    step();
    i_tx_start = 1'b0;
    w = 0;
    while (!done_w[0] && w < 400) begin
      step();
      w++;
    end
    chk(done_w[0], 1'b1, "b2b_done_seen", 0);
    i_data     = 8'h20;
    i_tx_start = 1'b1;
    step();
    i_tx_start = 1'b0;
    chk(tx_w[0], 1'b0, "b2b_start_bit", 0);
    run(220);

    // Randomised data and tick spacing
    tick_mode = 2;
    repeat (4) begin
      send(8'($urandom));
      w = 0;
      while ((m_busy[0] || m_busy[1] || m_busy[2]) && w < 1500) begin
        step();
        w++;
      end
      chk_int(int'(w < 1500), 1, "rand_frame_bound", 0);
      run(2);
    end

    // Asynchronous reset during data bit 4 of 0x0C
    tick_mode = 0;
    send(8'h0C);
    run(84);
    #2 i_rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      chk(tx_w[i], 1'b1, "rst_tx", i);
      chk(busy_w[i], 1'b0, "rst_busy", i);
      chk(done_w[i], 1'b0, "rst_done", i);
    end
    run(2);
    i_rst = 1'b0;
    run(2);
    clear_counts();
    send(8'h03);
    run(220);
    for (int i = 0; i < 3; i++) chk_int(done_cnt[i], 1, "post_rst_done", i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART serial transmitter. It is the TX counterpart of the oversampling UART receiver in the top level. It takes a parallel byte from the ALU/interface controller and shifts it out on RsTx, using the same baud-rate-generator tick (16 ticks per bit) and the same frame-format parameters as the receiver. It generates the start bit, the data bits (LSB first), an optional parity bit and the stop bits, then reports completion.

Parameters:
N_DATA, 8, data bits per frame.
LOG2_N_DATA, 4, width of the data-bit counter; must satisfy 2**LOG2_N_DATA > N_DATA.
PARITY_CHECK, 0, 1 = append a parity bit after the data bits; 0 = no parity bit.
EVEN_ODD_PARITY, 1, 0 = even parity (bit = XOR of data); 1 = odd parity (bit = ~XOR of data).
M_STOP, 1, number of stop bits.
LOG2_M_STOP, 1, width of the stop-bit counter; must satisfy 2**LOG2_M_STOP >= M_STOP.
N_TICKS, 16, i_tick pulses per bit period.

Ports:
i_clk  in  1  system clock; all logic on its rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_tick  in  1  baud x16 strobe from the baud generator; one i_clk cycle wide.
i_tx_start  in  1  request to transmit i_data; sampled only in IDLE.
i_data  in  N_DATA  byte to send; captured on the accepting cycle.
o_tx  out  1  serial line (RsTx); idles high.
o_busy  out  1  high from the cycle after acceptance until the frame ends.
o_tx_done  out  1  one-cycle pulse marking the end of a frame.

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - state = IDLE; o_tx = 1; o_busy = 0; o_tx_done = 0.
  - All counters and the shift register cleared.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_tx = 1.
  - If i_tx_start = 1: latch i_data into the shift register, compute and store the parity bit, clear the tick counter, and go to START on the next edge.
  - Acceptance does not wait for i_tick.
- Bit timing: a 4-bit tick counter increments on each i_tick.
  - A bit period ends on the cycle the counter is at N_TICKS-1 and i_tick = 1.
  - At that point the counter wraps to 0 and the FSM advances.
  - Each bit therefore lasts exactly N_TICKS i_tick pulses.
- START: o_tx = 0 for one bit period, then go to DATA with the bit counter = 0.
- DATA:
  - o_tx = shift register bit 0.
  - At each bit end: shift right by 1 and increment the bit counter.
  - After bit N_DATA-1, go to PARITY if PARITY_CHECK = 1, otherwise to STOP.
- PARITY: o_tx = stored parity bit for one bit period, then go to STOP.
- STOP:
  - o_tx = 1 for M_STOP bit periods, counted by the stop counter.
  - On the end of the final stop bit, go to IDLE.
- o_tx_done: asserted for exactly the first IDLE cycle after the frame ends.
- o_busy: 1 in every state except IDLE.
- o_tx must be registered (glitch-free). Its value changes only on the state/shift transitions above.
- i_tx_start while busy: ignored, with no queuing and no effect on the frame in flight.
- i_data changes during a frame: no effect; only the latched copy is transmitted.
- Back-to-back frames:
  - i_tx_start = 1 in the o_tx_done cycle is accepted, and START begins on the next edge.
  - The line stays high between the final stop bit and the new start bit for only that single IDLE cycle.
- i_tick in the same cycle as acceptance: not counted toward the start bit.
- Frame length: (1 + N_DATA + PARITY_CHECK + M_STOP) * N_TICKS ticks, plus one IDLE cycle.

Test Plan:
- Basic 8N1: defaults, i_tick every cycle, send 0x03. Required: o_tx = 0,1,1,0,0,0,0,0,0,1, each level held 16 cycles; o_busy high 160 cycles; o_tx_done pulses once; line then stays 1.
- Parity: PARITY_CHECK = 1, send 0x0C (two ones). Required: parity bit = 0 with EVEN_ODD_PARITY = 0, and 1 with EVEN_ODD_PARITY = 1; frame is 176 ticks.
- Two stop bits at realistic baud: M_STOP = 2, LOG2_M_STOP = 2, i_tick every 10 clocks, send 0x20. Required: bit 5 high, all other data bits low; stop level high for 32 ticks (320 clocks); o_tx_done about 1760 clocks after acceptance.
- Start while busy, then back-to-back: pulse i_tx_start with 0xFF during DATA of a 0x03 frame. Required: ignored, 0x03 sent unchanged. Then assert i_tx_start with 0x20 in the o_tx_done cycle. Required: next start bit begins on the following edge and 0x20 is sent correctly.
- Reset mid-frame: assert i_rst during bit 4 of 0x0C. Required: o_tx = 1, o_busy = 0, o_tx_done = 0 immediately, without waiting for a clock. After release, a new 0x03 frame is sent correctly.
